el2_trace_buf: RTL and testbench

Parametrised multi-channel instruction-trace capture buffer for the EL2 core. Accepts up to CHANNELS retirement trace records per cycle in the `el2_trace_pkt_t` field set, compacts them in channel order into a DEPTH-entry FIFO, and drains them one record per cycle over a valid/ready stream toward the trace port or debug module. Overflow is lossy but accounted for: dropped records are counted, and the next stored record is flagged.

---
 rtl/el2_trace_buf.sv | 167 ++++++++++++++++
 tb/tb_el2_trace_buf.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/el2_trace_buf.sv
// el2_trace_buf: compacts up to CHANNELS retire trace records per cycle into a DEPTH-entry FIFO and drains one per cycle.
// Latency: a record pushed in cycle N is at the head in N+1 (first-word-fall-through, no bypass into an empty FIFO).
// Backpressure: pushes are all-or-nothing against start-of-cycle occupancy; rejected records are counted and the next stored record is flagged.
//
// Ports:
//   clk, rst_l                    clock, asynchronous active-low reset
//   trace_en, flush               capture enable, synchronous clear (wins over push and pop)
//   in_valid/insn/addr/exc/ecause/intr/tval   per-lane records, lane i in slice i
//   out_valid/out_ready           head handshake
//   out_insn/addr/tval/exc/intr/ecause/ovf    head fields, zero while out_valid=0
//   count, drop_cnt               occupancy and saturating drop counter
// Build option: define EL2_TRACE_TVAL_EN to store and present tval; otherwise out_tval is tied to 0.
module el2_trace_buf #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  trace_en,
  input  logic                  flush,
  input  logic [CHANNELS-1:0]   in_valid,
  input  logic [32*CHANNELS-1:0] in_insn,
  input  logic [32*CHANNELS-1:0] in_addr,
  input  logic [CHANNELS-1:0]   in_exc,
  input  logic [5*CHANNELS-1:0] in_ecause,
  input  logic [CHANNELS-1:0]   in_intr,
  input  logic [32*CHANNELS-1:0] in_tval,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_insn,
  output logic [31:0]           out_addr,
  output logic [31:0]           out_tval,
  output logic                  out_exc,
  output logic                  out_intr,
  output logic [4:0]            out_ecause,
  output logic                  out_ovf,
  output logic [CW-1:0]         count,
  output logic [15:0]           drop_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(CHANNELS + 1);

  typedef struct packed {
`ifdef EL2_TRACE_TVAL_EN
    logic [31:0] tval;
`endif
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic [4:0]  ecause;
    logic        intr;
    logic        ovf;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        lane_rec [CHANNELS];
  logic [NW-1:0] lane_off [CHANNELS];
  logic [NW-1:0] n;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          ovf_pend;
  logic          accept;
  logic          reject;
  logic          pop;
  logic [31:0]   occ_sum;
  logic [31:0]   count_nxt;
  logic [16:0]   drop_sum;
  entry_t        head;

  // DEPTH is a power of two, so masking is the modulo; DEPTH=1 collapses to slot 0.
  function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input logic [31:0] off);
    logic [31:0] s;
    s = (32'(base) + off) & 32'(DEPTH - 1);
    return s[PW-1:0];
  endfunction

  // Each valid lane lands at wr_ptr plus the number of valid lanes below it,
  // which packs the records without gaps in ascending lane order.
  always_comb begin
    n = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lane_off[i] = n;
      if (trace_en && in_valid[i]) n = n + NW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      lane_rec[i]        = '0;
`ifdef EL2_TRACE_TVAL_EN
      lane_rec[i].tval   = in_tval[32*i +: 32];
`endif
      lane_rec[i].insn   = in_insn[32*i +: 32];
      lane_rec[i].addr   = in_addr[32*i +: 32];
      lane_rec[i].exc    = in_exc[i];
      lane_rec[i].ecause = in_ecause[5*i +: 5];
      lane_rec[i].intr   = in_intr[i];
      // Only the first record of the push carries the loss marker.
      lane_rec[i].ovf    = ovf_pend && (lane_off[i] == '0);
    end
  end

`ifndef EL2_TRACE_TVAL_EN
  logic unused_tval;
  assign unused_tval = ^in_tval;
`endif

  // Space is judged on the registered count only; a same-cycle pop does not make room.
  assign occ_sum   = 32'(count) + 32'(n);
  assign accept    = !flush && (n != '0) && (occ_sum <= 32'(DEPTH));
  assign reject    = !flush && (n != '0) && (occ_sum >  32'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign count_nxt = 32'(count) + (accept ? 32'(n) : 32'd0) - (pop ? 32'd1 : 32'd0);
  assign drop_sum  = {1'b0, drop_cnt} + 17'(n);

  // Storage holds no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (in_valid[i]) mem[slot(wr_ptr, 32'(lane_off[i]))] <= lane_rec[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_pend <= 1'b0;
      drop_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_pend <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (accept) wr_ptr <= slot(wr_ptr, 32'(n));
      if (pop)    rd_ptr <= slot(rd_ptr, 32'd1);
      count <= count_nxt[CW-1:0];
      if (reject) begin
        ovf_pend <= 1'b1;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end else if (accept) begin
        ovf_pend <= 1'b0;
      end
    end
  end

  assign head       = mem[rd_ptr];
  assign out_insn   = out_valid ? head.insn   : '0;
  assign out_addr   = out_valid ? head.addr   : '0;
  assign out_exc    = out_valid ? head.exc    : 1'b0;
  assign out_intr   = out_valid ? head.intr   : 1'b0;
  assign out_ecause = out_valid ? head.ecause : '0;
  assign out_ovf    = out_valid ? head.ovf    : 1'b0;
`ifdef EL2_TRACE_TVAL_EN
  assign out_tval   = out_valid ? head.tval   : '0;
`else
  assign out_tval   = '0;
`endif

endmodule

// File: tb/tb_el2_trace_buf.sv
// tb_el2_trace_buf: scoreboard bench for el2_trace_buf with CHANNELS=2, DEPTH=4.
// Stimulus updates a queue-based reference model; a monitor compares the head on every pop.
// Occupancy, valid and drop count are compared every cycle.
module tb_el2_trace_buf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        trace_en;
  logic        flush;
  logic [1:0]  in_valid;
  logic [63:0] in_insn;
  logic [63:0] in_addr;
  logic [1:0]  in_exc;
  logic [9:0]  in_ecause;
  logic [1:0]  in_intr;
  logic [63:0] in_tval;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [31:0] out_addr;
  logic [31:0] out_tval;
  logic        out_exc;
  logic        out_intr;
  logic [4:0]  out_ecause;
  logic        out_ovf;
  logic [2:0]  count;
  logic [15:0] drop_cnt;

  el2_trace_buf #(.CHANNELS(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_l(rst_l), .trace_en(trace_en), .flush(flush),
    .in_valid(in_valid), .in_insn(in_insn), .in_addr(in_addr), .in_exc(in_exc),
    .in_ecause(in_ecause), .in_intr(in_intr), .in_tval(in_tval),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_addr(out_addr), .out_tval(out_tval), .out_exc(out_exc), .out_intr(out_intr),
    .out_ecause(out_ecause), .out_ovf(out_ovf), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] addr;
    logic [31:0] tval;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic        ovf;
  } rec_t;

  rec_t q[$];
  int   mdrop = 0;
  bit   mpend = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One stimulus cycle: drive just after a rising edge, and apply the reference
  // rules for the edge that follows to the model.
  task automatic cyc(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                     input logic rdy, input logic fl, input logic en);
    rec_t        r;
    int          n;
    bit          first;
    logic [31:0] a [2];
    a[0] = a0;
    a[1] = a1;
    @(posedge clk);
    #2;
    trace_en  = en;
    flush     = fl;
    out_ready = rdy;
    in_valid  = v;
    for (int i = 0; i < 2; i++) begin
      in_insn[32*i +: 32]  = $urandom;
      in_addr[32*i +: 32]  = a[i];
      in_tval[32*i +: 32]  = $urandom;
      in_exc[i]            = 1'($urandom);
      in_intr[i]           = 1'($urandom);
      in_ecause[5*i +: 5]  = 5'($urandom);
    end
    if (fl) begin
      q.delete();
      mdrop = 0;
      mpend = 0;
    end else begin
      n = en ? (int'(v[0]) + int'(v[1])) : 0;
      if (n > 0) begin
        if (q.size() + n <= DEPTH) begin
          first = 1;
          for (int i = 0; i < 2; i++) begin
            if (v[i]) begin
              r.insn   = in_insn[32*i +: 32];
              r.addr   = in_addr[32*i +: 32];
`ifdef EL2_TRACE_TVAL_EN
              r.tval   = in_tval[32*i +: 32];
`else
              r.tval   = 32'h0;
`endif
              r.exc    = in_exc[i];
              r.intr   = in_intr[i];
              r.ecause = in_ecause[5*i +: 5];
              r.ovf    = mpend && first;
              first    = 0;
              q.push_back(r);
            end
          end
          mpend = 0;
        end else begin
          mdrop = (mdrop + n > 65535) ? 65535 : mdrop + n;
          mpend = 1;
        end
      end
    end
  endtask

  // Monitor: state checks 1 time unit after each edge, head comparison on pops.
  initial begin
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_l) begin
        chk("count", 64'(count), 64'(q.size()));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
        if (!out_valid)
          chk("idle_zero", 64'((out_insn | out_addr | out_tval) != 0 || out_exc || out_intr
                               || out_ecause != 0 || out_ovf), 64'(0));
      end
      #2;
      if (rst_l && out_valid && out_ready && !flush) begin
        if (q.size() == 0) begin
          chk("pop_empty", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          chk("pop_addr", 64'(out_addr), 64'(e.addr));
          chk("pop_insn", 64'(out_insn), 64'(e.insn));
          chk("pop_tval", 64'(out_tval), 64'(e.tval));
          chk("pop_flags", 64'({out_exc, out_intr, out_ecause, out_ovf}),
              64'({e.exc, e.intr, e.ecause, e.ovf}));
        end
      end
    end
  end

  initial begin
    rst_l = 1'b0; trace_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = '0; in_insn = '0; in_addr = '0; in_exc = '0;
    in_ecause = '0; in_intr = '0; in_tval = '0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    chk("rst_data", 64'({out_insn | out_addr | out_tval, out_exc, out_intr, out_ecause, out_ovf}), 64'(0));
    #21;
    rst_l = 1'b1;

    // Single lane.
    cyc(2'b01, 32'h1000, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("single_addr", 64'(out_addr), 64'h1000);
    chk("single_count", 64'(count), 64'(1));
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("single_drained", 64'(count), 64'(0));
    chk("single_addr0", 64'(out_addr), 64'(0));

    // Two lanes in one cycle.
    cyc(2'b11, 32'h2000, 32'h2004, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("dual_head", 64'(out_addr), 64'h2000);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("dual_second", 64'(out_addr), 64'h2004);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Lane-1-only push compacts into the next slot.
    cyc(2'b10, 32'h0, 32'h3000, 1'b0, 1'b0, 1'b1);
    cyc(2'b01, 32'h3004, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("compact_count", 64'(count), 64'(2));
    chk("compact_head", 64'(out_addr), 64'h3000);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Overflow, drop count and loss flag.
    cyc(2'b11, 32'h3100, 32'h3104, 1'b0, 1'b0, 1'b1);
    cyc(2'b01, 32'h3108, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(2'b11, 32'h3200, 32'h3204, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("ovf_drop2", 64'(drop_cnt), 64'(2));
    chk("ovf_count3", 64'(count), 64'(3));
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(2'b01, 32'h4000, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("ovf_rec_addr", 64'(out_addr), 64'h4000);
    chk("ovf_rec_flag", 64'(out_ovf), 64'(1));
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Single pushes interleaved with pops cross the pointer wrap.
    for (int k = 0; k < 6; k++) cyc(2'b01, 32'h5000 + 32'(4 * k), 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Flush wins over a simultaneous push and clears the drop count.
    cyc(2'b11, 32'h6000, 32'h6004, 1'b0, 1'b0, 1'b1);
    cyc(2'b11, 32'h6008, 32'h600c, 1'b0, 1'b1, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_drop", 64'(drop_cnt), 64'(0));
    chk("flush_valid", 64'(out_valid), 64'(0));

    // Disabled capture ignores valid lanes.
    cyc(2'b11, 32'h7000, 32'h7004, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("disabled_count", 64'(count), 64'(0));

    // Full with pop and push: push rejected, pop completes.
    cyc(2'b11, 32'h8000, 32'h8004, 1'b0, 1'b0, 1'b1);
    cyc(2'b11, 32'h8008, 32'h800c, 1'b0, 1'b0, 1'b1);
    cyc(2'b11, 32'h8010, 32'h8014, 1'b1, 1'b0, 1'b1);
    cyc(2'b11, 32'h8018, 32'h801c, 1'b0, 1'b0, 1'b1);
    chk("full_pop_push", 64'(count), 64'(DEPTH - 1));
    cyc(2'b01, 32'h8020, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(2'b01, 32'h8024, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_count", 64'(count), 64'(3));
    chk("pre_rst_drop", 64'(drop_cnt), 64'(5));

    // Asynchronous reset mid-stream.
    rst_l = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_drop", 64'(drop_cnt), 64'(0));
    chk("arst_data", 64'({out_insn | out_addr | out_tval, out_exc, out_intr, out_ecause, out_ovf}), 64'(0));
    q.delete();
    mdrop = 0;
    mpend = 0;
    @(posedge clk);
    #2;
    rst_l = 1'b1;

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++)
      cyc(2'($urandom), $urandom, $urandom, 1'($urandom),
          $urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0);

    // Drop counter saturation.
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    cyc(2'b11, 32'h9000, 32'h9004, 1'b0, 1'b0, 1'b1);
    cyc(2'b11, 32'h9008, 32'h900c, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 32800; k++) cyc(2'b11, 32'ha000, 32'ha004, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("drop_saturate", 64'(drop_cnt), 64'hFFFF);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("final_drop", 64'(drop_cnt), 64'(0));
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
